// File: rtl/mips_ctrl_pkg.sv
// Shared opcodes, ALU-op codes and the control bundle
// for the ID stage decoder and ID/EX register.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_BGE   = 6'd1;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_BGT   = 6'd7;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [3:0] ALU_R    = 4'd0;
  localparam logic [3:0] ALU_ADDI = 4'd1;
  localparam logic [3:0] ALU_SLTI = 4'd2;
  localparam logic [3:0] ALU_BEQ  = 4'd3;
  localparam logic [3:0] ALU_SW   = 4'd4;
  localparam logic [3:0] ALU_LW   = 4'd5;
  localparam logic [3:0] ALU_BNE  = 4'd6;
  localparam logic [3:0] ALU_BGE  = 4'd7;
  localparam logic [3:0] ALU_BGT  = 4'd8;

  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic       reg_dst;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic [3:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/decode_ctrl.sv
// Combinational opcode decoder: control bundle,
// legality and whether the rt field is a source.
module decode_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int EXT_BRANCH = 1
) (
  input  logic [5:0] i_op,
  output ctrl_t      o_ctrl,
  output logic       o_legal,
  output logic       o_uses_rt
);

  localparam logic EXT = (EXT_BRANCH != 0);

  logic w_bge;
  logic w_bgt;

  assign w_bge = EXT & (i_op == OP_BGE);
  assign w_bgt = EXT & (i_op == OP_BGT);

  always_comb begin
    o_ctrl  = CTRL_NOP;
    o_legal = 1'b1;
    unique case (1'b1)
      (i_op == OP_RTYPE): begin
        o_ctrl.alu_op    = ALU_R;
        o_ctrl.reg_dst   = 1'b1;
        o_ctrl.reg_write = 1'b1;
      end
      (i_op == OP_ADDI): begin
        o_ctrl.alu_op    = ALU_ADDI;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.reg_write = 1'b1;
      end
      (i_op == OP_SLTI): begin
        o_ctrl.alu_op    = ALU_SLTI;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.reg_write = 1'b1;
      end
      (i_op == OP_BEQ): begin
        o_ctrl.alu_op = ALU_BEQ;
        o_ctrl.branch = 1'b1;
      end
      (i_op == OP_SW): begin
        o_ctrl.alu_op    = ALU_SW;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.mem_write = 1'b1;
      end
      (i_op == OP_LW): begin
        o_ctrl.alu_op     = ALU_LW;
        o_ctrl.alu_src    = 1'b1;
        o_ctrl.mem_read   = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.reg_write  = 1'b1;
      end
      (i_op == OP_BNE): begin
        o_ctrl.alu_op = ALU_BNE;
        o_ctrl.branch = 1'b1;
      end
      w_bge: begin
        o_ctrl.alu_op = ALU_BGE;
        o_ctrl.branch = 1'b1;
      end
      w_bgt: begin
        o_ctrl.alu_op = ALU_BGT;
        o_ctrl.branch = 1'b1;
      end
      default: o_legal = 1'b0;
    endcase
  end

  // rt is a source for these even when extended branches are disabled
  assign o_uses_rt = (i_op == OP_RTYPE) | (i_op == OP_BEQ)
                   | (i_op == OP_BNE)   | (i_op == OP_BGE)
                   | (i_op == OP_BGT)   | (i_op == OP_SW);

endmodule

// File: rtl/id_ex_decoder.sv
// ID stage: decode, load-use hazard detection, ID/EX
// pipeline register and saturating illegal-opcode counter.
module id_ex_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int ALU_OP_W   = 4,
  parameter int REG_AW     = 5,
  parameter int CNT_W      = 8,
  parameter int EXT_BRANCH = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [31:0]         instr_i,
  input  logic                instr_valid_i,
  input  logic                stall_i,
  input  logic                flush_i,
  output logic                id_hold_o,
  output logic                ex_valid_o,
  output logic                ex_RegWrite_o,
  output logic [ALU_OP_W-1:0] ex_ALU_op_o,
  output logic                ex_ALUSrc_o,
  output logic                ex_RegDst_o,
  output logic                ex_Branch_o,
  output logic                ex_MemRead_o,
  output logic                ex_MemtoReg_o,
  output logic                ex_MemWrite_o,
  output logic [REG_AW-1:0]   ex_rs_o,
  output logic [REG_AW-1:0]   ex_rt_o,
  output logic [REG_AW-1:0]   ex_rd_o,
  output logic                ex_illegal_o,
  output logic [CNT_W-1:0]    illegal_cnt_o
);

  logic [5:0]        w_op;
  logic [REG_AW-1:0] w_rs;
  logic [REG_AW-1:0] w_rt;
  logic [REG_AW-1:0] w_rd;
  ctrl_t             w_ctrl;
  logic              w_legal;
  logic              w_uses_rt;
  logic              w_hazard;
  logic              w_ld_valid;
  logic              w_ld_ill;
  logic              w_unused;

  ctrl_t             r_ctrl;
  logic              r_valid;
  logic [REG_AW-1:0] r_rs;
  logic [REG_AW-1:0] r_rt;
  logic [REG_AW-1:0] r_rd;
  logic              r_illegal;
  logic [CNT_W-1:0]  r_cnt;

  assign w_op     = instr_i[31:26];
  assign w_rs     = REG_AW'(instr_i[25:21]);
  assign w_rt     = REG_AW'(instr_i[20:16]);
  assign w_rd     = REG_AW'(instr_i[15:11]);
  assign w_unused = ^instr_i[10:0];

  decode_ctrl #(
    .EXT_BRANCH(EXT_BRANCH)
  ) u_dec (
    .i_op      (w_op),
    .o_ctrl    (w_ctrl),
    .o_legal   (w_legal),
    .o_uses_rt (w_uses_rt)
  );

  // After the bubble r_valid is 0, so the check never fires twice
  assign w_hazard = r_valid & r_ctrl.mem_read
                  & (r_rt != '0)
                  & instr_valid_i & ~flush_i
                  & ((r_rt == w_rs)
                    | (w_uses_rt & (r_rt == w_rt)));

  assign id_hold_o  = stall_i | w_hazard;
  assign w_ld_valid = instr_valid_i & w_legal;
  assign w_ld_ill   = instr_valid_i & ~w_legal;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ctrl    <= CTRL_NOP;
      r_valid   <= 1'b0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rd      <= '0;
      r_illegal <= 1'b0;
      r_cnt     <= '0;
    end else if (flush_i || (!stall_i && w_hazard)) begin
      r_ctrl    <= CTRL_NOP;
      r_valid   <= 1'b0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rd      <= '0;
      r_illegal <= 1'b0;
    end else if (stall_i) begin
      r_illegal <= 1'b0;
    end else begin
      r_ctrl    <= w_ld_valid ? w_ctrl : CTRL_NOP;
      r_valid   <= w_ld_valid;
      r_rs      <= w_ld_valid ? w_rs : '0;
      r_rt      <= w_ld_valid ? w_rt : '0;
      r_rd      <= w_ld_valid ? w_rd : '0;
      r_illegal <= w_ld_ill;
      if (w_ld_ill && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign ex_valid_o    = r_valid;
  assign ex_RegWrite_o = r_ctrl.reg_write;
  assign ex_ALU_op_o   = ALU_OP_W'(r_ctrl.alu_op);
  assign ex_ALUSrc_o   = r_ctrl.alu_src;
  assign ex_RegDst_o   = r_ctrl.reg_dst;
  assign ex_Branch_o   = r_ctrl.branch;
  assign ex_MemRead_o  = r_ctrl.mem_read;
  assign ex_MemtoReg_o = r_ctrl.mem_to_reg;
  assign ex_MemWrite_o = r_ctrl.mem_write;
  assign ex_rs_o       = r_rs;
  assign ex_rt_o       = r_rt;
  assign ex_rd_o       = r_rd;
  assign ex_illegal_o  = r_illegal;
  assign illegal_cnt_o = r_cnt;

endmodule

// File: tb/tb_id_ex_decoder.sv
// Bench for id_ex_decoder: directed cases plus random
// traffic against a cycle-level reference model.
module tb_id_ex_decoder;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] instr = '0;
  logic        valid = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;

  logic       hold, ev, rw, asrc, rdst, br, mr, m2r, mw, ill;
  logic [3:0] alu;
  logic [4:0] rs, rt, rd;
  logic [7:0] cnt;

  logic       hold0, ev0, rw0, asrc0, rdst0, br0, mr0, m2r0, mw0;
  logic       ill0;
  logic [3:0] alu0;
  logic [4:0] rs0, rt0, rd0;
  logic [7:0] cnt0;

  int checks = 0;
  int errors = 0;

  logic       m_v, m_ill;
  logic [3:0] m_alu;
  logic [6:0] m_ctl;
  logic [4:0] m_rs, m_rt, m_rd;
  int         m_cnt;

  always #5 clk = ~clk;

  id_ex_decoder u_dut (
    .clk_i(clk), .rst_i(rst_i), .instr_i(instr),
    .instr_valid_i(valid), .stall_i(stall),
    .flush_i(flush), .id_hold_o(hold),
    .ex_valid_o(ev), .ex_RegWrite_o(rw),
    .ex_ALU_op_o(alu), .ex_ALUSrc_o(asrc),
    .ex_RegDst_o(rdst), .ex_Branch_o(br),
    .ex_MemRead_o(mr), .ex_MemtoReg_o(m2r),
    .ex_MemWrite_o(mw), .ex_rs_o(rs),
    .ex_rt_o(rt), .ex_rd_o(rd),
    .ex_illegal_o(ill), .illegal_cnt_o(cnt)
  );

  id_ex_decoder #(.EXT_BRANCH(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst_i), .instr_i(instr),
    .instr_valid_i(valid), .stall_i(stall),
    .flush_i(flush), .id_hold_o(hold0),
    .ex_valid_o(ev0), .ex_RegWrite_o(rw0),
    .ex_ALU_op_o(alu0), .ex_ALUSrc_o(asrc0),
    .ex_RegDst_o(rdst0), .ex_Branch_o(br0),
    .ex_MemRead_o(mr0), .ex_MemtoReg_o(m2r0),
    .ex_MemWrite_o(mw0), .ex_rs_o(rs0),
    .ex_rt_o(rt0), .ex_rd_o(rd0),
    .ex_illegal_o(ill0), .illegal_cnt_o(cnt0)
  );

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // {legal, alu[3:0], RegWrite ALUSrc RegDst Branch
  //  MemRead MemtoReg MemWrite}
  function automatic logic [11:0] ref_dec(logic [5:0] op);
    case (op)
      6'd0:  return {1'b1, 4'd0, 7'b1010000};
      6'd8:  return {1'b1, 4'd1, 7'b1100000};
      6'd10: return {1'b1, 4'd2, 7'b1100000};
      6'd4:  return {1'b1, 4'd3, 7'b0001000};
      6'd43: return {1'b1, 4'd4, 7'b0100001};
      6'd35: return {1'b1, 4'd5, 7'b1100110};
      6'd5:  return {1'b1, 4'd6, 7'b0001000};
      6'd1:  return {1'b1, 4'd7, 7'b0001000};
      6'd7:  return {1'b1, 4'd8, 7'b0001000};
      default: return 12'd0;
    endcase
  endfunction

  function automatic bit ref_haz();
    logic [5:0] op;
    bit ur;
    op = instr[31:26];
    ur = op inside {6'd0, 6'd4, 6'd5, 6'd1, 6'd7, 6'd43};
    return m_v && m_ctl[2] && m_rt != 0 && valid
      && !flush && (m_rt == instr[25:21]
      || (ur && m_rt == instr[20:16]));
  endfunction

  task automatic m_clear(bit keep_cnt);
    m_v = 0; m_ill = 0; m_alu = 0; m_ctl = 0;
    m_rs = 0; m_rt = 0; m_rd = 0;
    if (!keep_cnt) m_cnt = 0;
  endtask

  task automatic m_update(bit haz);
    logic [11:0] d;
    bit ok;
    d = ref_dec(instr[31:26]);
    if (flush || (!stall && haz)) begin
      m_clear(1);
    end else if (stall) begin
      m_ill = 0;
    end else begin
      ok = valid && d[11];
      m_v = ok;
      m_alu = ok ? d[10:7] : 4'd0;
      m_ctl = ok ? d[6:0] : 7'd0;
      m_rs = ok ? instr[25:21] : 5'd0;
      m_rt = ok ? instr[20:16] : 5'd0;
      m_rd = ok ? instr[15:11] : 5'd0;
      m_ill = valid && !d[11];
      if (m_ill && m_cnt < 255) m_cnt++;
    end
  endtask

  task automatic check_all();
    chk("ex_valid", 32'(ev), 32'(m_v));
    chk("ctl", 32'({rw, asrc, rdst, br, mr, m2r, mw}),
        32'(m_ctl));
    chk("alu_op", 32'(alu), 32'(m_alu));
    chk("rs", 32'(rs), 32'(m_rs));
    chk("rt", 32'(rt), 32'(m_rt));
    chk("rd", 32'(rd), 32'(m_rd));
    chk("illegal", 32'(ill), 32'(m_ill));
    chk("cnt", 32'(cnt), 32'(m_cnt));
  endtask

  task automatic step(logic [31:0] ins, bit v, bit st,
                      bit fl);
    bit haz;
    instr = ins; valid = v; stall = st; flush = fl;
    @(negedge clk);
    haz = ref_haz();
    chk("id_hold", 32'(hold), 32'(st | haz));
    @(posedge clk);
    m_update(haz);
    #1;
    check_all();
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] ops [11];
    logic [31:0] ins;
    ops = '{6'd0, 6'd8, 6'd10, 6'd4, 6'd43, 6'd35,
            6'd5, 6'd1, 6'd7, 6'h3F, 6'd2};
    m_clear(0);

    rst_i = 0; valid = 1; instr = 32'h2001_0005;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("rst_hold", 32'(hold), 32'd0);
    rst_i = 1;

    step(32'h2001_0005, 1, 0, 0);
    chk("addi_alu", 32'(alu), 32'd1);
    chk("addi_rt", 32'(rt), 32'd1);

    step(32'h1C22_0000, 1, 0, 0);
    chk("bgt_ext1_br", 32'(br), 32'd1);
    chk("bgt_ext0_ill", 32'(ill0), 32'd1);
    chk("bgt_ext0_cnt", 32'(cnt0), 32'd1);

    step(32'h8C22_0000, 1, 0, 0);
    step(32'h0044_1820, 1, 0, 0);
    chk("lu_hold_bubble", 32'(ev), 32'd0);
    step(32'h0044_1820, 1, 0, 0);
    chk("lu_add_rs", 32'(rs), 32'd2);

    step(32'h8C20_0000, 1, 0, 0);
    step(32'h0000_1820, 1, 0, 0);
    step(32'h8C22_0000, 1, 0, 0);
    step(32'h20C5_0007, 1, 0, 0);

    step(32'h1022_0003, 1, 0, 0);
    step(32'h2001_0005, 1, 1, 1);
    chk("flush_br", 32'(br), 32'd0);

    step(32'h2003_0009, 1, 0, 0);
    repeat (3) step(32'h8C22_0000, 1, 1, 0);
    chk("stall_rt", 32'(rt), 32'd3);
    step(32'h8C22_0000, 1, 0, 0);

    instr = 32'h0044_1820; valid = 1;
    #1;
    chk("pre_rst_hold", 32'(hold), 32'd1);
    rst_i = 0;
    #1;
    chk("mid_rst_hold", 32'(hold), 32'd0);
    chk("mid_rst_valid", 32'(ev), 32'd0);
    m_clear(0);
    @(posedge clk);
    #1 rst_i = 1;

    repeat (300) step(32'hFC00_0000, 1, 0, 0);
    chk("cnt_sat", 32'(cnt), 32'd255);

    ins = 32'h2001_0005;
    for (int i = 0; i < 400; i++) begin
      if (!hold) begin
        ins = $urandom;
        ins[31:26] = ops[$urandom_range(10)];
        ins[25:21] = 5'($urandom_range(3));
        ins[20:16] = 5'($urandom_range(3));
      end
      step(ins, $urandom_range(9) != 0,
           $urandom_range(6) == 0, $urandom_range(9) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
